// File: rtl/ds2431_pkg.sv
// Shared definitions for the DS2431 emulator CRC path: sequencer state
// encoding, CRC width, requester ids and the single-bit CRC-16/MAXIM step.
package ds2431_pkg;

    localparam int CRC_W = 16;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // Reflected form of the 0x8005 polynomial, bits shifted in LSB first.
    localparam logic [CRC_W-1:0] CRC_POLY_REF = 16'hA001;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        TRIG,
        WAIT,
        FIN
    } seq_state_t;

    // Advance the reflected CRC register by one input bit.
    function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                     input logic din);
        logic fb;
        fb = crc[0] ^ din;
        crc16_step = (crc >> 1) ^ (CRC_POLY_REF & {CRC_W{fb}});
    endfunction

endpackage

// File: rtl/crc16.sv
// CRC-16/MAXIM byte engine. A trig seen while done=1 starts a byte; the
// engine then walks inDat LSB first, one bit per clock, so inDat must stay
// stable until done returns high. Init 0x0000, result is the inverted register.
module crc16
    import ds2431_pkg::*;
(
    input  logic             clk,
    input  logic             nRst,
    input  logic             trig,
    output logic             done,
    input  logic [7:0]       inDat,
    output logic [CRC_W-1:0] result
);

    logic [CRC_W-1:0] crc;
    logic [2:0]       bit_idx;

    // Idle until triggered, then shift eight bits and raise done again.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            crc     <= '0;
            bit_idx <= '0;
            done    <= 1'b1;
        end else if (done) begin
            if (trig) begin
                done    <= 1'b0;
                bit_idx <= '0;
            end
        end else begin
            crc     <= crc16_step(crc, inDat[bit_idx]);
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
                done <= 1'b1;
            end
        end
    end

    assign result = ~crc;

endmodule

// File: rtl/crc16_seq.sv
// Session controller for the shared CRC-16/MAXIM engine. Arbitrates two
// byte-stream requesters, clears the engine at the start of every session,
// paces bytes through the trig/done handshake and returns the final CRC.
// Optional feature macro: CRC16_SEQ_CHECK_EN (compare result against crcExp).
module crc16_seq
    import ds2431_pkg::*;
#(
    parameter int TMO_CYC = 32,
    parameter int CNT_W   = 8
)
(
    input  logic             clk,
    input  logic             nRst,
    input  logic             aStart,
    input  logic             aValid,
    input  logic [7:0]       aDat,
    input  logic             aLast,
    output logic             aReady,
    input  logic             bStart,
    input  logic             bValid,
    input  logic [7:0]       bDat,
    input  logic             bLast,
    output logic             bReady,
    output logic             owner,
    output logic             busy,
    output logic [CRC_W-1:0] crcOut,
    output logic             crcValid,
    output logic [CNT_W-1:0] byteCnt,
    output logic             tmoErr,
    input  logic [CRC_W-1:0] crcExp,
    output logic             crcOk
);

    localparam int WD_W = $clog2(TMO_CYC + 1);

    seq_state_t       state;
    seq_state_t       next_state;

    logic             eng_n;
    logic             eng_trig;
    logic             eng_done;
    logic [7:0]       eng_dat;
    logic [CRC_W-1:0] eng_result;

    logic             last_q;
    logic             last_owner;
    logic             winner;
    logic             own_valid;
    logic             own_last;
    logic [7:0]       own_dat;
    logic             accept;
    logic             timeout;
    logic [WD_W-1:0]  wd_cnt;

    crc16 u_crc (
        .clk    (clk),
        .nRst   (eng_n),
        .trig   (eng_trig),
        .done   (eng_done),
        .inDat  (eng_dat),
        .result (eng_result)
    );

    assign own_valid = (owner == OWNER_B) ? bValid : aValid;
    assign own_dat   = (owner == OWNER_B) ? bDat   : aDat;
    assign own_last  = (owner == OWNER_B) ? bLast  : aLast;
    assign accept    = (state == LOAD) && own_valid;

    // The watchdog fires once the engine has spent TMO_CYC cycles on one byte.
    assign timeout = ((state == TRIG) || (state == WAIT))
                     && (wd_cnt == WD_W'(TMO_CYC - 1))
                     && !((state == WAIT) && eng_done);

    // Grant selection: a tie goes to whoever did not own the previous session.
    always_comb begin
        winner = OWNER_A;
        if (aStart && bStart) begin
            winner = ~last_owner;
        end else if (bStart) begin
            winner = OWNER_B;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode for the session sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (aStart || bStart) next_state = CLEAR;
            CLEAR:   next_state = LOAD;
            LOAD:    if (own_valid) next_state = TRIG;
            TRIG: begin
                if (timeout) begin
                    next_state = IDLE;
                end else if (!eng_done) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (eng_done) begin
                    next_state = last_q ? FIN : LOAD;
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ready goes only to the current owner, in the cycle its byte is taken.
    always_comb begin
        aReady = accept && (owner == OWNER_A);
        bReady = accept && (owner == OWNER_B);
    end

    // Session datapath: grant, byte latch, counters, engine controls, result.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            owner      <= OWNER_A;
            last_owner <= OWNER_B;
            busy       <= 1'b0;
            byteCnt    <= '0;
            eng_dat    <= '0;
            last_q     <= 1'b0;
            wd_cnt     <= '0;
            crcOut     <= '0;
            crcValid   <= 1'b0;
            tmoErr     <= 1'b0;
            eng_trig   <= 1'b0;
            eng_n      <= 1'b0;
        end else begin
            crcValid <= 1'b0;
            tmoErr   <= 1'b0;
            eng_trig <= (next_state == TRIG);
            eng_n    <= (next_state != CLEAR);
            case (state)
                IDLE: begin
                    if (aStart || bStart) begin
                        owner      <= winner;
                        last_owner <= winner;
                        busy       <= 1'b1;
                        byteCnt    <= '0;
                    end
                end
                LOAD: begin
                    if (own_valid) begin
                        eng_dat <= own_dat;
                        last_q  <= own_last;
                        wd_cnt  <= '0;
                        if (byteCnt != {CNT_W{1'b1}}) begin
                            byteCnt <= byteCnt + 1'b1;
                        end
                    end
                end
                TRIG, WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (timeout) begin
                        tmoErr <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                FIN: begin
                    crcOut   <= eng_result;
                    crcValid <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef CRC16_SEQ_CHECK_EN
    // Compare the final CRC against the expected value alongside crcValid.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            crcOk <= 1'b0;
        end else if (state == FIN) begin
            crcOk <= (eng_result == crcExp);
        end
    end
`else
    logic unused_crc_exp;
    assign unused_crc_exp = ^crcExp;
    assign crcOk          = 1'b0;
`endif

endmodule

// File: tb/tb_crc16_seq.sv
// Self-checking bench for crc16_seq: randomized sessions from both requesters
// compared against a byte-wise CRC-16/MAXIM reference model.
module tb_crc16_seq;

    localparam int TMO_CYC = 32;
    localparam int CNT_W   = 8;
`ifdef CRC16_SEQ_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic             clk;
    logic             nRst;
    logic             aStart, aValid, aLast, aReady;
    logic [7:0]       aDat;
    logic             bStart, bValid, bLast, bReady;
    logic [7:0]       bDat;
    logic             owner, busy, crcValid, tmoErr, crcOk;
    logic [15:0]      crcOut, crcExp;
    logic [CNT_W-1:0] byteCnt;

    int          pass_cnt;
    int          total_cnt;
    int          valid_pulses;
    int          nonowner_ready_cnt;
    logic        sess_on;
    logic        cur_owner;
    logic [15:0] last_exp_crc;

    crc16_seq #(.TMO_CYC(TMO_CYC), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .nRst     (nRst),
        .aStart   (aStart),
        .aValid   (aValid),
        .aDat     (aDat),
        .aLast    (aLast),
        .aReady   (aReady),
        .bStart   (bStart),
        .bValid   (bValid),
        .bDat     (bDat),
        .bLast    (bLast),
        .bReady   (bReady),
        .owner    (owner),
        .busy     (busy),
        .crcOut   (crcOut),
        .crcValid (crcValid),
        .byteCnt  (byteCnt),
        .tmoErr   (tmoErr),
        .crcExp   (crcExp),
        .crcOk    (crcOk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count result pulses and any Ready handed to the requester that does not own the session.
    always @(negedge clk) begin
        if (crcValid) valid_pulses++;
        if (sess_on && ((cur_owner == 1'b0 && bReady) || (cur_owner == 1'b1 && aReady)))
            nonowner_ready_cnt++;
    end

    // Reference CRC-16/MAXIM: whole byte folded in, then eight reflected shifts.
    function automatic logic [15:0] model_crc(input logic [7:0] data[$]);
        logic [15:0] c;
        c = 16'h0000;
        foreach (data[i]) begin
            c = c ^ {8'h00, data[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic int model_cnt(input int n);
        int top;
        top = (1 << CNT_W) - 1;
        return (n > top) ? top : n;
    endfunction

    // Run one complete session for requester 'who'; outputs are zeroed when the session stalls.
    task automatic run_session(input logic who, input logic tie, input logic noise,
                               input logic [7:0] data[$], input int max_gap,
                               output logic got_valid, output logic [15:0] got_crc,
                               output int got_cnt, output logic got_owner,
                               output logic got_ok, output logic got_busy);
        int   guard;
        logic seen;
        got_valid = 1'b0; got_crc = '0; got_cnt = 0; got_owner = 1'b0; got_ok = 1'b0; got_busy = 1'b1;
        @(negedge clk);
        aStart = (who == 1'b0) || tie;
        bStart = (who == 1'b1) || tie;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!busy && guard < 20);
        aStart = 1'b0; bStart = 1'b0;
        if (!busy) return;
        got_owner = owner;
        cur_owner = who;
        sess_on   = 1'b1;
        foreach (data[i]) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            if (who == 1'b0) begin
                aValid = 1'b1; aDat = data[i]; aLast = (i == data.size() - 1);
                bValid = noise & 1'($urandom_range(0, 1)); bDat = 8'($urandom); bLast = 1'($urandom_range(0, 1));
            end else begin
                bValid = 1'b1; bDat = data[i]; bLast = (i == data.size() - 1);
                aValid = noise & 1'($urandom_range(0, 1)); aDat = 8'($urandom); aLast = 1'($urandom_range(0, 1));
            end
            #1;
            guard = 0;
            seen  = who ? bReady : aReady;
            while (!seen && guard < 64) begin
                @(negedge clk); #1; guard++;
                seen = who ? bReady : aReady;
            end
            @(negedge clk);
            aValid = 1'b0; bValid = 1'b0; aLast = 1'b0; bLast = 1'b0;
            if (!seen) begin sess_on = 1'b0; return; end
        end
        guard = 0;
        while (!crcValid && guard < 64) begin @(negedge clk); guard++; end
        if (crcValid) begin
            got_valid = 1'b1; got_crc = crcOut; got_cnt = int'(byteCnt); got_ok = crcOk; got_busy = busy;
        end
        sess_on = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        aStart = 0; aValid = 0; aDat = 0; aLast = 0;
        bStart = 0; bValid = 0; bDat = 0; bLast = 0;
        crcExp = 16'h0000;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (owner !== 1'b0) $display("[TB] FAIL reset_owner: got %b expected 0", owner); else pass_cnt++;
        total_cnt++; if ({aReady, bReady} !== 2'b00) $display("[TB] FAIL reset_ready: got %b expected 00", {aReady, bReady}); else pass_cnt++;
        total_cnt++; if (crcOut !== 16'h0000) $display("[TB] FAIL reset_crcOut: got %h expected 0000", crcOut); else pass_cnt++;
        total_cnt++; if ({crcValid, tmoErr, crcOk} !== 3'b000) $display("[TB] FAIL reset_pulses: got %b expected 000", {crcValid, tmoErr, crcOk}); else pass_cnt++;
        total_cnt++; if (byteCnt !== '0) $display("[TB] FAIL reset_byteCnt: got %0d expected 0", byteCnt); else pass_cnt++;
        nRst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tie_round_robin();
        logic [7:0]  q[$];
        logic [15:0] exp_crc, got_crc;
        logic        got_valid, got_owner, got_ok, got_busy;
        int          got_cnt, nr0;
        for (int pass = 0; pass < 2; pass++) begin
            q = {};
            repeat ($urandom_range(1, 5)) q.push_back(8'($urandom));
            exp_crc = model_crc(q);
            crcExp  = exp_crc;
            nr0     = nonowner_ready_cnt;
            run_session(1'(pass), 1'b1, 1'b1, q, 2, got_valid, got_crc, got_cnt, got_owner, got_ok, got_busy);
            total_cnt++; if (got_owner !== 1'(pass)) $display("[TB] FAIL tie_owner%0d: got %b expected %0d", pass, got_owner, pass); else pass_cnt++;
            total_cnt++; if (got_valid !== 1'b1 || got_crc !== exp_crc) $display("[TB] FAIL tie_crc%0d: got %h (valid %b) expected %h", pass, got_crc, got_valid, exp_crc); else pass_cnt++;
            total_cnt++; if (nonowner_ready_cnt !== nr0) $display("[TB] FAIL tie_nonowner_ready%0d: got %0d expected 0", pass, nonowner_ready_cnt - nr0); else pass_cnt++;
            last_exp_crc = exp_crc;
        end
    endtask

    task automatic test_check_string();
        logic [7:0]  q[$];
        logic [15:0] got_crc;
        logic        got_valid, got_owner, got_ok, got_busy;
        int          got_cnt, p0;
        q = {};
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        crcExp = 16'h44C2;
        p0 = valid_pulses;
        run_session(1'b0, 1'b0, 1'b0, q, 0, got_valid, got_crc, got_cnt, got_owner, got_ok, got_busy);
        total_cnt++; if (got_crc !== 16'h44C2) $display("[TB] FAIL check_crc: got %h expected 44c2", got_crc); else pass_cnt++;
        total_cnt++; if (got_cnt !== 9) $display("[TB] FAIL check_byteCnt: got %0d expected 9", got_cnt); else pass_cnt++;
        total_cnt++; if (valid_pulses - p0 !== 1) $display("[TB] FAIL check_valid_once: got %0d expected 1", valid_pulses - p0); else pass_cnt++;
        total_cnt++; if (got_busy !== 1'b0) $display("[TB] FAIL check_busy_done: got %b expected 0", got_busy); else pass_cnt++;
        total_cnt++; if (got_ok !== CHK) $display("[TB] FAIL check_ok_match: got %b expected %b", got_ok, CHK); else pass_cnt++;
        crcExp = 16'h44C3;
        run_session(1'b0, 1'b0, 1'b0, q, 1, got_valid, got_crc, got_cnt, got_owner, got_ok, got_busy);
        total_cnt++; if (got_valid !== 1'b1 || got_crc !== 16'h44C2) $display("[TB] FAIL check_crc_again: got %h expected 44c2", got_crc); else pass_cnt++;
        total_cnt++; if (got_ok !== 1'b0) $display("[TB] FAIL check_ok_mismatch: got %b expected 0", got_ok); else pass_cnt++;
        last_exp_crc = 16'h44C2;
    endtask

    task automatic test_clear_per_session();
        logic [7:0]  q[$];
        logic [15:0] exp_crc, got_crc, first_crc;
        logic        got_valid, got_owner, got_ok, got_busy;
        int          got_cnt;
        q = {8'($urandom), 8'($urandom), 8'($urandom)};
        exp_crc = model_crc(q);
        run_session(1'b1, 1'b0, 1'b1, q, 1, got_valid, got_crc, got_cnt, got_owner, got_ok, got_busy);
        total_cnt++; if (got_crc !== exp_crc) $display("[TB] FAIL clear_lead_crc: got %h expected %h", got_crc, exp_crc); else pass_cnt++;
        q = {8'h00};
        exp_crc = model_crc(q);
        run_session(1'b1, 1'b0, 1'b1, q, 0, got_valid, got_crc, got_cnt, got_owner, got_ok, got_busy);
        first_crc = got_crc;
        total_cnt++; if (got_crc !== exp_crc || got_cnt !== 1) $display("[TB] FAIL clear_zero1: got %h/%0d expected %h/1", got_crc, got_cnt, exp_crc); else pass_cnt++;
        run_session(1'b1, 1'b0, 1'b1, q, 0, got_valid, got_crc, got_cnt, got_owner, got_ok, got_busy);
        total_cnt++; if (got_crc !== first_crc || got_crc !== exp_crc) $display("[TB] FAIL clear_zero2: got %h expected %h", got_crc, exp_crc); else pass_cnt++;
        last_exp_crc = exp_crc;
    endtask

    task automatic test_random_sessions();
        logic [7:0]  q[$];
        logic [15:0] exp_crc, got_crc;
        logic        who, got_valid, got_owner, got_ok, got_busy;
        int          got_cnt;
        for (int s = 0; s < 6; s++) begin
            who = 1'($urandom_range(0, 1));
            q = {};
            repeat ($urandom_range(1, 12)) q.push_back(8'($urandom));
            exp_crc = model_crc(q);
            crcExp  = exp_crc ^ ((s % 2 == 1) ? 16'h0100 : 16'h0000);
            run_session(who, 1'b0, 1'b1, q, 3, got_valid, got_crc, got_cnt, got_owner, got_ok, got_busy);
            total_cnt++; if (got_valid !== 1'b1 || got_crc !== exp_crc) $display("[TB] FAIL rand_crc%0d: got %h expected %h", s, got_crc, exp_crc); else pass_cnt++;
            total_cnt++; if (got_cnt !== model_cnt(q.size()) || got_owner !== who) $display("[TB] FAIL rand_cnt_owner%0d: got %0d/%b expected %0d/%b", s, got_cnt, got_owner, q.size(), who); else pass_cnt++;
            total_cnt++; if (got_ok !== (CHK && (crcExp == exp_crc))) $display("[TB] FAIL rand_ok%0d: got %b expected %b", s, got_ok, CHK && (crcExp == exp_crc)); else pass_cnt++;
            last_exp_crc = exp_crc;
        end
    endtask

    task automatic test_saturation();
        logic [7:0]  q[$];
        logic [15:0] exp_crc, got_crc;
        logic        got_valid, got_owner, got_ok, got_busy;
        int          got_cnt;
        q = {};
        repeat (260) q.push_back(8'($urandom));
        exp_crc = model_crc(q);
        run_session(1'b1, 1'b0, 1'b1, q, 0, got_valid, got_crc, got_cnt, got_owner, got_ok, got_busy);
        total_cnt++; if (got_cnt !== model_cnt(260)) $display("[TB] FAIL sat_byteCnt: got %0d expected %0d", got_cnt, model_cnt(260)); else pass_cnt++;
        total_cnt++; if (got_crc !== exp_crc) $display("[TB] FAIL sat_crc: got %h expected %h", got_crc, exp_crc); else pass_cnt++;
        last_exp_crc = exp_crc;
    endtask

    task automatic test_timeout();
        logic [7:0]  q[$];
        logic [15:0] exp_crc, got_crc;
        logic        seen, got_valid, got_owner, got_ok, got_busy;
        int          guard, n, p0, got_cnt;
        p0 = valid_pulses;
        @(negedge clk);
        aStart = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!busy && guard < 20);
        aStart = 1'b0; cur_owner = 1'b0; sess_on = 1'b1;
        aValid = 1'b1; aDat = 8'($urandom); aLast = 1'b1;
        #1;
        guard = 0;
        while (!aReady && guard < 64) begin @(negedge clk); #1; guard++; end
        seen = aReady;
        force dut.eng_done = 1'b0;
        @(negedge clk);
        aValid = 1'b0; aLast = 1'b0;
        n = 1;
        while (!tmoErr && n < 200) begin @(negedge clk); n++; end
        total_cnt++; if (seen !== 1'b1) $display("[TB] FAIL tmo_accept: got %b expected 1", seen); else pass_cnt++;
        total_cnt++; if (n !== TMO_CYC + 1) $display("[TB] FAIL tmo_latency: got %0d expected %0d", n, TMO_CYC + 1); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL tmo_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (crcOut !== last_exp_crc) $display("[TB] FAIL tmo_crcOut: got %h expected %h", crcOut, last_exp_crc); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (tmoErr !== 1'b0) $display("[TB] FAIL tmo_pulse_width: got %b expected 0", tmoErr); else pass_cnt++;
        total_cnt++; if (valid_pulses !== p0) $display("[TB] FAIL tmo_no_valid: got %0d expected 0", valid_pulses - p0); else pass_cnt++;
        release dut.eng_done;
        sess_on = 1'b0;
        q = {8'($urandom), 8'($urandom)};
        exp_crc = model_crc(q);
        run_session(1'b0, 1'b0, 1'b0, q, 1, got_valid, got_crc, got_cnt, got_owner, got_ok, got_busy);
        total_cnt++; if (got_valid !== 1'b1 || got_crc !== exp_crc) $display("[TB] FAIL tmo_recover: got %h expected %h", got_crc, exp_crc); else pass_cnt++;
        last_exp_crc = exp_crc;
    endtask

    task automatic test_reset_mid_session();
        logic [7:0]  q[$];
        logic [15:0] got_crc;
        logic        got_valid, got_owner, got_ok, got_busy;
        int          guard, fed, p0, got_cnt;
        q = {};
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        @(negedge clk);
        bStart = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!busy && guard < 20);
        bStart = 1'b0; cur_owner = 1'b1; sess_on = 1'b1;
        fed = 0;
        for (int i = 0; i < 4; i++) begin
            bValid = 1'b1; bDat = q[i]; bLast = 1'b0;
            #1;
            guard = 0;
            while (!bReady && guard < 64) begin @(negedge clk); #1; guard++; end
            if (bReady) fed++;
            @(negedge clk);
            bValid = 1'b0;
        end
        repeat (3) @(negedge clk);
        total_cnt++; if (fed !== 4 || byteCnt !== 8'd4) $display("[TB] FAIL mid_feed: got %0d/%0d expected 4/4", fed, byteCnt); else pass_cnt++;
        p0 = valid_pulses;
        nRst = 1'b0;
        #1;
        total_cnt++; if ({busy, owner, bReady, crcValid, tmoErr, crcOk} !== 6'b0) $display("[TB] FAIL mid_reset_flags: got %b expected 000000", {busy, owner, bReady, crcValid, tmoErr, crcOk}); else pass_cnt++;
        total_cnt++; if (crcOut !== 16'h0000 || byteCnt !== '0) $display("[TB] FAIL mid_reset_data: got %h/%0d expected 0000/0", crcOut, byteCnt); else pass_cnt++;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        sess_on = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (valid_pulses !== p0) $display("[TB] FAIL mid_reset_no_valid: got %0d expected 0", valid_pulses - p0); else pass_cnt++;
        run_session(1'b0, 1'b0, 1'b0, q, 0, got_valid, got_crc, got_cnt, got_owner, got_ok, got_busy);
        total_cnt++; if (got_valid !== 1'b1 || got_crc !== 16'h44C2 || got_cnt !== 9) $display("[TB] FAIL mid_reset_fresh: got %h/%0d expected 44c2/9", got_crc, got_cnt); else pass_cnt++;
    endtask

    // Hard stop if any wait escapes its bound.
    initial begin
        #5ms;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        pass_cnt = 0; total_cnt = 0; valid_pulses = 0; nonowner_ready_cnt = 0;
        sess_on = 1'b0; cur_owner = 1'b0; last_exp_crc = 16'h0000;
        test_reset();
        test_tie_round_robin();
        test_check_string();
        test_clear_per_session();
        test_random_sessions();
        test_saturation();
        test_timeout();
        test_reset_mid_session();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
